modport_arbiter: RTL and testbench

Two-requester, single-output arbiter. It accepts a request and a data word from each of two masters, grants at most one master per cycle, and forwards the granted master's data on a registered output bus. It sits behind the arbiter bus interface: the masters drive `req_x`/`data_inx`, and the arbiter drives the grant and output signals as the slave side.

---
 rtl/arbi_pkg.sv | 16 +
 rtl/arbi_pick.sv | 33 +++
 rtl/modport_arbiter.sv | 66 ++++++
 tb/tb_modport_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/arbi_pkg.sv
// Shared types and constants for the two-master arbiter.
// The ARBI_ROUND_ROBIN_EN macro selects the contention policy inside arbi_pick.
package arbi_pkg;

    localparam int ARBI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_0,
        GNT_1
    } grant_sel_e;

    // Pointer starts at master 1 so master 0 wins the first contention.
    localparam logic LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/arbi_pick.sv
// Combinational grant decision for two requesters.
// ARBI_ROUND_ROBIN_EN defined: round-robin on contention; undefined: master 0 wins.
import arbi_pkg::*;

module arbi_pick (
    input  logic       req_0,
    input  logic       req_1,
    input  logic       last_gnt,
    output grant_sel_e sel
);

`ifndef ARBI_ROUND_ROBIN_EN
    // The pointer is still tracked by the top level but does not steer fixed priority.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        sel = GNT_NONE;
        if (req_0 && req_1) begin
`ifdef ARBI_ROUND_ROBIN_EN
            sel = last_gnt ? GNT_0 : GNT_1;
`else
            sel = GNT_0;
`endif
        end else if (req_0) begin
            sel = GNT_0;
        end else if (req_1) begin
            sel = GNT_1;
        end
    end

endmodule

// File: rtl/modport_arbiter.sv
// Two-master arbiter: registered grants, registered data of the winner, priority pointer.
// Contention policy is chosen by ARBI_ROUND_ROBIN_EN (see arbi_pick).
import arbi_pkg::*;

module modport_arbiter #(
    parameter int DATA_WIDTH = ARBI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] data_in1,
    output logic                  grant_0,
    output logic                  grant_1,
    output logic [DATA_WIDTH-1:0] arb_out
);

    grant_sel_e            sel;
    logic                  grant_0_reg;
    logic                  grant_1_reg;
    logic [DATA_WIDTH-1:0] arb_out_reg;
    logic                  last_gnt_reg;

    arbi_pick u_pick (
        .req_0    (req_0),
        .req_1    (req_1),
        .last_gnt (last_gnt_reg),
        .sel      (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_0_reg  <= 1'b0;
            grant_1_reg  <= 1'b0;
            arb_out_reg  <= '0;
            last_gnt_reg <= LAST_GNT_RST;
        end else begin
            case (sel)
                GNT_0: begin
                    grant_0_reg  <= 1'b1;
                    grant_1_reg  <= 1'b0;
                    arb_out_reg  <= data_in0;
                    last_gnt_reg <= 1'b0;
                end
                GNT_1: begin
                    grant_0_reg  <= 1'b0;
                    grant_1_reg  <= 1'b1;
                    arb_out_reg  <= data_in1;
                    last_gnt_reg <= 1'b1;
                end
                default: begin
                    // Idle cycle: pointer holds its value.
                    grant_0_reg  <= 1'b0;
                    grant_1_reg  <= 1'b0;
                    arb_out_reg  <= '0;
                end
            endcase
        end
    end

    assign grant_0 = grant_0_reg;
    assign grant_1 = grant_1_reg;
    assign arb_out = arb_out_reg;

endmodule

// File: tb/tb_modport_arbiter.sv
// Self-checking bench for modport_arbiter against a behavioural arbitration model.
// Define ARBI_ROUND_ROBIN_EN for both bench and RTL to check the round-robin build.
module tb_modport_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_0 = 1'b0;
    logic          req_1 = 1'b0;
    logic [DW-1:0] data_in0 = '0;
    logic [DW-1:0] data_in1 = '0;
    logic          grant_0;
    logic          grant_1;
    logic [DW-1:0] arb_out;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: index of the most recently granted master.
    int            model_last = 1;
    logic [DW+1:0] exp_v;
    logic [DW+1:0] act_v;

    modport_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_0    (req_0),
        .data_in0 (data_in0),
        .req_1    (req_1),
        .data_in1 (data_in1),
        .grant_0  (grant_0),
        .grant_1  (grant_1),
        .arb_out  (arb_out)
    );

    always #5 clk = ~clk;

    // Applies one cycle of inputs, predicts the outputs, and returns #1 after the sampling edge.
    task automatic drive_cycle(input logic rst, input logic r0, input logic r1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int winner;
        reset    = rst;
        req_0    = r0;
        req_1    = r1;
        data_in0 = d0;
        data_in1 = d1;
        winner   = -1;
        if (rst) begin
            model_last = 1;
        end else if (r0 && r1) begin
`ifdef ARBI_ROUND_ROBIN_EN
            winner = 1 - model_last;
`else
            winner = 0;
`endif
        end else if (r0) begin
            winner = 0;
        end else if (r1) begin
            winner = 1;
        end
        if (winner == 0)      exp_v = {1'b1, 1'b0, d0};
        else if (winner == 1) exp_v = {1'b0, 1'b1, d1};
        else                  exp_v = '0;
        if (winner >= 0) model_last = winner;
        @(posedge clk);
        #1;
        act_v = {grant_0, grant_1, arb_out};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
            tests_run++;
            if (act_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset[%0d] got g0=%b g1=%b out=%h want g0=%b g1=%b out=%h",
                         i, act_v[DW+1], act_v[DW], act_v[DW-1:0], exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
            end else $display("[TB] reset[%0d] ok", i);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB);
        tests_run++;
        if (act_v !== exp_v || grant_0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_contention got g0=%b g1=%b out=%h want g0=1 g1=0 out=%h",
                     grant_0, grant_1, arb_out, exp_v[DW-1:0]);
        end else $display("[TB] reset_first_contention ok");
    endtask

    task automatic test_single_master0();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 32'hDEAD_BEEF);
            tests_run++;
            if (act_v !== exp_v || act_v !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
                tests_failed++;
                $display("FAIL single0[%0d] got g0=%b g1=%b out=%h want g0=1 g1=0 out=a5a50001",
                         i, grant_0, grant_1, arb_out);
            end else $display("[TB] single0[%0d] out=%h ok", i, arb_out);
        end
    endtask

    task automatic test_contention();
        drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 32'd1, 32'd2);
            tests_run++;
            if (act_v !== exp_v) begin
                tests_failed++;
                $display("FAIL contention[%0d] got g0=%b g1=%b out=%h want g0=%b g1=%b out=%h",
                         i, grant_0, grant_1, arb_out, exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
            end else $display("[TB] contention[%0d] g0=%b g1=%b out=%0d ok", i, grant_0, grant_1, arb_out);
        end
    endtask

    task automatic test_idle_gap();
        drive_cycle(1'b0, 1'b1, 1'b1, 32'd1, 32'd2);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'd7, 32'd8);
        tests_run++;
        if (act_v !== '0) begin
            tests_failed++;
            $display("FAIL idle_gap got g0=%b g1=%b out=%h want all zero", grant_0, grant_1, arb_out);
        end else $display("[TB] idle_gap ok");
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 32'd1, 32'd2);
            tests_run++;
            if (act_v !== exp_v) begin
                tests_failed++;
                $display("FAIL after_gap[%0d] got g0=%b g1=%b out=%h want g0=%b g1=%b out=%h",
                         i, grant_0, grant_1, arb_out, exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
            end else $display("[TB] after_gap[%0d] ok", i);
        end
    endtask

    task automatic test_reset_mid_grant();
        drive_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'h0BAD_F00D);
        tests_run++;
        if (act_v !== {1'b0, 1'b1, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL mid_setup got g0=%b g1=%b out=%h want g0=0 g1=1 out=0badf00d",
                     grant_0, grant_1, arb_out);
        end else $display("[TB] mid_setup ok");
        drive_cycle(1'b1, 1'b0, 1'b1, 32'd0, 32'h0BAD_F00D);
        tests_run++;
        if (act_v !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset got g0=%b g1=%b out=%h want all zero", grant_0, grant_1, arb_out);
        end else $display("[TB] mid_reset ok");
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0033, 32'h0000_0044);
        tests_run++;
        if (act_v !== {1'b1, 1'b0, 32'h0000_0033}) begin
            tests_failed++;
            $display("FAIL mid_after got g0=%b g1=%b out=%h want g0=1 g1=0 out=00000033",
                     grant_0, grant_1, arb_out);
        end else $display("[TB] mid_after ok");
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            tests_run++;
            if ((grant_0 & grant_1) !== 1'b0 || act_v !== exp_v) begin
                tests_failed++;
                errs++;
                if (errs <= 20)
                    $display("FAIL random[%0d] got g0=%b g1=%b out=%h want g0=%b g1=%b out=%h",
                             i, grant_0, grant_1, arb_out, exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
            end else $display("[TB] random[%0d] g0=%b g1=%b out=%h ok", i, grant_0, grant_1, arb_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_master0();
        test_contention();
        test_idle_gap();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
